// File: rtl/out_channel_reader_if.sv
// Stream bundle for the program output channel.
// The producer side pushes words and the consumer side drains them over valid/ready.
interface out_channel_reader_if #(
  parameter int MemoryElementWidth = 12
);
  logic                          outWrite;
  logic [MemoryElementWidth-1:0] outData;
  logic                          rdValid;
  logic [MemoryElementWidth-1:0] rdData;
  logic                          rdReady;

  modport master (
    output outWrite,
    output outData,
    output rdReady,
    input  rdValid,
    input  rdData
  );

  modport slave (
    input  outWrite,
    input  outData,
    input  rdReady,
    output rdValid,
    output rdData
  );
endinterface

// File: rtl/out_channel_reader.sv
// Consumer end of the program output channel: circular buffer drained over valid/ready,
// with delivery count, sticky drop/protocol flags and a done indication after finish.
module out_channel_reader #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 3,
  parameter int CountWidth         = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  out_channel_reader_if.slave          chan,
  input  logic                         finished,
  output logic                         outFull,
  output logic [$clog2(NOut+1)-1:0]    level,
  output logic [CountWidth-1:0]        delivered,
  output logic                         overflow,
  output logic                         protoError,
  output logic                         done
);

  localparam int LevelWidth = $clog2(NOut + 1);
  localparam int PtrWidth   = (NOut > 1) ? $clog2(NOut) : 1;

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StFlush = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(NOut - 1)) begin
      nextPtr = '0;
    end else begin
      nextPtr = p + PtrWidth'(1);
    end
  endfunction

  logic [MemoryElementWidth-1:0] mem_r [NOut];
  logic [PtrWidth-1:0]           wrPos_r;
  logic [PtrWidth-1:0]           rdPos_r;
  logic [LevelWidth-1:0]         level_r;
  logic                          outFull_r;
  logic                          rdValid_r;
  logic [MemoryElementWidth-1:0] rdData_r;
  logic [CountWidth-1:0]         delivered_r;
  logic                          overflow_r;
  logic                          protoError_r;
  logic                          done_r;
  logic [1:0]                    state_r;

  logic                          inDone_s;
  logic                          pop_s;
  logic                          push_s;
  logic                          drop_s;
  logic [PtrWidth-1:0]           wrPosNext_s;
  logic [PtrWidth-1:0]           rdPosNext_s;
  logic [LevelWidth-1:0]         levelNext_s;
  logic [MemoryElementWidth-1:0] rdDataNext_s;
  logic [1:0]                    stateNext_s;

  // Buffer bookkeeping for this cycle's push/pop
  always_comb begin
    inDone_s    = (state_r == StDone);
    pop_s       = rdValid_r && chan.rdReady;
    push_s      = chan.outWrite && !inDone_s && ((level_r < LevelWidth'(NOut)) || pop_s);
    drop_s      = chan.outWrite && !inDone_s && !push_s;
    wrPosNext_s = push_s ? nextPtr(wrPos_r) : wrPos_r;
    rdPosNext_s = pop_s ? nextPtr(rdPos_r) : rdPos_r;
    case ({push_s, pop_s})
      2'b10:   levelNext_s = level_r + LevelWidth'(1);
      2'b01:   levelNext_s = level_r - LevelWidth'(1);
      default: levelNext_s = level_r;
    endcase
    // The new head is the word being written when it lands on the next read slot
    if (push_s && (wrPos_r == rdPosNext_s)) begin
      rdDataNext_s = chan.outData;
    end else begin
      rdDataNext_s = mem_r[rdPosNext_s];
    end
  end

  // Run/flush/done sequencing; finished is only looked at while running
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      StRun: begin
        if (finished) begin
          stateNext_s = (levelNext_s == '0) ? StDone : StFlush;
        end else begin
          stateNext_s = StRun;
        end
      end
      StFlush: begin
        if (levelNext_s == '0) begin
          stateNext_s = StDone;
        end else begin
          stateNext_s = StFlush;
        end
      end
      StDone:  stateNext_s = StDone;
      default: stateNext_s = StRun;
    endcase
  end

  // State, storage and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NOut; i++) begin
        mem_r[i] <= '0;
      end
      wrPos_r      <= '0;
      rdPos_r      <= '0;
      level_r      <= '0;
      outFull_r    <= 1'b0;
      rdValid_r    <= 1'b0;
      rdData_r     <= '0;
      delivered_r  <= '0;
      overflow_r   <= 1'b0;
      protoError_r <= 1'b0;
      done_r       <= 1'b0;
      state_r      <= StRun;
    end else begin
      if (push_s) begin
        mem_r[wrPos_r] <= chan.outData;
      end
      wrPos_r   <= wrPosNext_s;
      rdPos_r   <= rdPosNext_s;
      level_r   <= levelNext_s;
      outFull_r <= (levelNext_s == LevelWidth'(NOut));
      rdValid_r <= (levelNext_s != '0);
      rdData_r  <= rdDataNext_s;
      if (pop_s) begin
        delivered_r <= delivered_r + CountWidth'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (chan.outWrite && inDone_s) begin
        protoError_r <= 1'b1;
      end
      // done trails DONE entry by one cycle
      done_r  <= inDone_s;
      state_r <= stateNext_s;
    end
  end

  assign chan.rdValid = rdValid_r;
  assign chan.rdData  = rdData_r;
  assign outFull      = outFull_r;
  assign level        = level_r;
  assign delivered    = delivered_r;
  assign overflow     = overflow_r;
  assign protoError   = protoError_r;
  assign done         = done_r;

endmodule
